i2s_rx: RTL

I2S receiver that deserialises a Philips-format stereo stream (SCK, WS, SD) into parallel left/right sample pairs in the system clock domain. It is the receive counterpart of the `i2s_tx` serializer and uses the same framing: WS low = left, MSB one SCK after each WS edge, SD changing on SCK falling edges. SCK, WS and SD are external, asynchronous inputs that are oversampled by `clk_i`. Completed stereo frames go out through a valid/ready holding register.

---
 rtl/i2s_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - Philips I2S receiver: oversampled SCK/WS/SD to parallel stereo frames
`timescale 1ns/1ps

module i2s_rx #(
    parameter int AUDIO_DW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic                sd_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    output logic                short_o
);

    localparam int CW = $clog2(AUDIO_DW + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(AUDIO_DW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sck_sync, ws_sync, sd_sync;
    logic       sck_prev;
    logic       sck_s, ws_s, sd_s;
    logic       rise;
    logic       ws_prev, primed, ws_chg;

    logic [CW-1:0]       cnt, cnt_sh, cnt_nxt;
    logic [AUDIO_DW-1:0] word, word_sh, word_nxt, word_out;
    logic [AUDIO_DW-1:0] l_hold;
    logic                active, shift_en, full_done, short_done;
    logic                left_done, right_done;

    // Equal-depth synchronisers keep WS/SD aligned with the SCK edge that samples them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync <= 2'b00;
            ws_sync  <= 2'b00;
            sd_sync  <= 2'b00;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck_i};
            ws_sync  <= {ws_sync[0], ws_i};
            sd_sync  <= {sd_sync[0], sd_i};
            sck_prev <= sck_sync[1];
        end
    end

    assign sck_s = sck_sync[1];
    assign ws_s  = ws_sync[1];
    assign sd_s  = sd_sync[1];
    assign rise  = sck_s & ~sck_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ws_prev <= 1'b0;
            primed  <= 1'b0;
        end else if (rise) begin
            ws_prev <= ws_s;
            primed  <= 1'b1;
        end
    end

    assign ws_chg = primed & (ws_s ^ ws_prev);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rise && ws_chg) begin
            case (state)
                S_IDLE:  if (!ws_s) state_nxt = S_LEFT;
                S_LEFT:  if (ws_s)  state_nxt = S_RIGHT;
                S_RIGHT: if (!ws_s) state_nxt = S_LEFT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // The bit on the WS-change rise still belongs to the ending slot, so shift first, then close
    always_comb begin
        active     = rise & (state != S_IDLE);
        shift_en   = active & (cnt < CNT_MAX);
        word_sh    = shift_en ? {word[AUDIO_DW-2:0], sd_s} : word;
        cnt_sh     = shift_en ? cnt + 1'b1 : cnt;
        full_done  = shift_en & (cnt_sh == CNT_MAX);
        short_done = active & ws_chg & (cnt_sh < CNT_MAX);
        word_out   = short_done ? (word_sh << (CNT_MAX - cnt_sh)) : word_sh;
        left_done  = (full_done | short_done) & (state == S_LEFT);
        right_done = (full_done | short_done) & (state == S_RIGHT);
        cnt_nxt    = cnt_sh;
        word_nxt   = word_sh;
        if (rise && ws_chg) begin
            cnt_nxt  = '0;
            word_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            word   <= '0;
            l_hold <= '0;
        end else begin
            cnt  <= cnt_nxt;
            word <= word_nxt;
            if (left_done) begin
                l_hold <= word_out;
            end
        end
    end

    // Holding register: a new frame may replace one being accepted in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            l_data_o  <= '0;
            r_data_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            short_o   <= 1'b0;
        end else begin
            short_o   <= short_done;
            overrun_o <= 1'b0;
            if (right_done) begin
                if (!valid_o || ready_i) begin
                    l_data_o <= l_hold;
                    r_data_o <= word_out;
                    valid_o  <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
